// File: rtl/ysyx_23060278_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings, reset PC, NOP word and
// the PC alignment helper.
package ysyx_23060278_ifu_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;
  localparam logic [31:0] IFU_NOP      = 32'h0000_0013;

  function automatic logic [31:0] pc_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ysyx_23060278_ifu_pc_gen.sv
// PC register and next-PC selection (reset / redirect / pc+4 / hold).
// With IFU_MISALIGN_CHK_EN a misaligned redirect target leaves the PC unchanged; otherwise it is masked.
module ysyx_23060278_pc_gen
  import ysyx_23060278_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_redirect_en,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_advance,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_next;

  // Redirect always wins over the sequential increment.
  always_comb begin
    w_pc_next = r_pc;
    if (i_redirect_en) begin
`ifdef IFU_MISALIGN_CHK_EN
      if (i_redirect_pc[1:0] == 2'b00) w_pc_next = i_redirect_pc;
`else
      w_pc_next = pc_align(i_redirect_pc);
`endif
    end else if (i_advance) begin
      w_pc_next = r_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_pc <= RESET_PC;
    else     r_pc <= w_pc_next;
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/ysyx_23060278_ifu.sv
// Instruction fetch unit: REQ/WAIT/HOLD fetch FSM, one outstanding imem request, registered
// instruction buffer towards decode. IFU_MISALIGN_CHK_EN adds the sticky fetch_err halt.
module ysyx_23060278_ifu
  import ysyx_23060278_ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = IFU_RESET_PC,
  parameter int          XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
`ifdef IFU_MISALIGN_CHK_EN
  ,
  output logic            fetch_err
`endif
);

  ifu_state_e  r_state;
  ifu_state_e  w_state_next;
  logic        r_drop;
  logic        w_drop_next;
  logic [31:0] r_inst;
  logic        w_inst_load;
  logic        w_advance;
  logic        w_req_valid;
  logic        w_inst_valid;
  logic [31:0] w_pc;
  logic        w_halt;
  logic        w_bad_redirect;

`ifdef IFU_MISALIGN_CHK_EN
  logic r_fetch_err;

  always_ff @(posedge clk) begin
    if (rst)                 r_fetch_err <= 1'b0;
    else if (w_bad_redirect) r_fetch_err <= 1'b1;
  end

  assign w_halt         = r_fetch_err;
  assign w_bad_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00) && !r_fetch_err;
  assign fetch_err      = r_fetch_err;
`else
  assign w_halt         = 1'b0;
  assign w_bad_redirect = 1'b0;
`endif

  ysyx_23060278_pc_gen #(
    .RESET_PC(RESET_PC)
  ) u_pc_gen (
    .clk          (clk),
    .rst          (rst),
    .i_redirect_en(redirect_valid),
    .i_redirect_pc(redirect_pc),
    .i_advance    (w_advance),
    .o_pc         (w_pc)
  );

  always_comb begin
    w_state_next = r_state;
    w_drop_next  = r_drop;
    w_inst_load  = 1'b0;
    w_advance    = 1'b0;
    w_req_valid  = 1'b0;
    w_inst_valid = 1'b0;
    case (r_state)
      ST_REQ: begin
        w_req_valid = !w_halt && !w_bad_redirect;
        // A redirect in the accept cycle still lets the old request go; its response is dropped.
        if (w_req_valid && imem_req_ready) begin
          w_state_next = ST_WAIT;
          w_drop_next  = redirect_valid;
        end
      end
      ST_WAIT: begin
        if (imem_resp_valid) begin
          w_drop_next = 1'b0;
          if (r_drop || redirect_valid) begin
            w_state_next = ST_REQ;
          end else begin
            w_inst_load  = 1'b1;
            w_state_next = ST_HOLD;
          end
        end else if (redirect_valid) begin
          w_drop_next = 1'b1;
        end
      end
      ST_HOLD: begin
        w_inst_valid = 1'b1;
        if (inst_ready) begin
          w_advance    = !redirect_valid;
          w_state_next = ST_REQ;
        end else if (redirect_valid) begin
          w_state_next = ST_REQ;
        end
      end
      default: begin
        w_state_next = ST_REQ;
        w_drop_next  = 1'b0;
      end
    endcase
    if (w_bad_redirect) begin
      w_state_next = ST_REQ;
      w_drop_next  = 1'b0;
      w_inst_load  = 1'b0;
      w_advance    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_REQ;
      r_drop  <= 1'b0;
      r_inst  <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_drop  <= w_drop_next;
      if (w_inst_load) r_inst <= imem_resp_data;
    end
  end

  assign imem_req_valid = w_req_valid && !rst;
  assign imem_req_addr  = w_pc;
  assign inst_valid     = w_inst_valid && !rst;
  assign inst           = r_inst;
  assign inst_pc        = w_pc;

endmodule

// File: tb/tb_ysyx_23060278_ifu.sv
// Directed bench for ysyx_23060278_ifu: per-cycle vector table plus hand sequences for mid-run
// reset and misaligned redirects (IFU_MISALIGN_CHK_EN-aware).
module tb_ysyx_23060278_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef IFU_MISALIGN_CHK_EN
  logic        fetch_err;
`endif

  always #5 clk = ~clk;

  ysyx_23060278_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IFU_MISALIGN_CHK_EN
    ,
    .fetch_err      (fetch_err)
`endif
  );

  typedef struct {
    logic        rdy;
    logic        rsp;
    logic [31:0] rdata;
    logic        ird;
    logic        redv;
    logic [31:0] rpc;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic outstanding = 1'b0;

  function automatic vec_t mk(logic rdy, logic rsp, logic [31:0] rdata, logic ird, logic redv,
                              logic [31:0] rpc, logic e_rv, logic [31:0] e_addr, logic e_iv,
                              logic [31:0] e_inst, logic [31:0] e_ipc);
    vec_t v;
    v.rdy = rdy; v.rsp = rsp; v.rdata = rdata; v.ird = ird; v.redv = redv; v.rpc = rpc;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_ipc = e_ipc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rsp, input logic [31:0] rdata,
                       input logic ird, input logic redv, input logic [31:0] rpc);
    imem_req_ready  = rdy;
    imem_resp_valid = rsp;
    imem_resp_data  = rdata;
    inst_ready      = ird;
    redirect_valid  = redv;
    redirect_pc     = rpc;
  endtask

  initial begin
    // rdy rsp data ird redv rpc | req_valid addr inst_valid inst inst_pc
    vq.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0,  1, 32'h8000_0000, 0, 32'h0, 32'h0));
    vq.push_back(mk(0, 1, 32'hAAAA_0001, 0, 0, 32'h0,  0, 32'h0, 0, 32'h0, 32'h0));
    vq.push_back(mk(0, 0, 32'h0, 1, 0, 32'h0,  0, 32'h0, 1, 32'hAAAA_0001, 32'h8000_0000));
    vq.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0,  1, 32'h8000_0004, 0, 32'h0, 32'h0));
    vq.push_back(mk(0, 1, 32'h1111_0002, 0, 0, 32'h0,  0, 32'h0, 0, 32'h0, 32'h0));
    for (int k = 0; k < 5; k++)
      vq.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0,  0, 32'h0, 1, 32'h1111_0002, 32'h8000_0004));
    vq.push_back(mk(1, 0, 32'h0, 1, 1, 32'h8000_0100,  0, 32'h0, 1, 32'h1111_0002, 32'h8000_0004));
    vq.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0,  1, 32'h8000_0100, 0, 32'h0, 32'h0));
    vq.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0,  1, 32'h8000_0100, 0, 32'h0, 32'h0));
    vq.push_back(mk(0, 0, 32'h0, 0, 1, 32'h8000_0200,  0, 32'h0, 0, 32'h0, 32'h0));
    vq.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0,  0, 32'h0, 0, 32'h0, 32'h0));
    vq.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0,  0, 32'h0, 0, 32'h0, 32'h0));
    vq.push_back(mk(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0,  0, 32'h0, 0, 32'h0, 32'h0));
    vq.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0,  1, 32'h8000_0200, 0, 32'h0, 32'h0));
    vq.push_back(mk(0, 1, 32'h2222_0003, 0, 0, 32'h0,  0, 32'h0, 0, 32'h0, 32'h0));
    vq.push_back(mk(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC,  0, 32'h0, 1, 32'h2222_0003, 32'h8000_0200));
    vq.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0,  1, 32'hFFFF_FFFC, 0, 32'h0, 32'h0));
    vq.push_back(mk(0, 1, 32'h3333_0004, 0, 0, 32'h0,  0, 32'h0, 0, 32'h0, 32'h0));
    vq.push_back(mk(0, 0, 32'h0, 1, 0, 32'h0,  0, 32'h0, 1, 32'h3333_0004, 32'hFFFF_FFFC));
    vq.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0,  1, 32'h0000_0000, 0, 32'h0, 32'h0));
    vq.push_back(mk(1, 0, 32'h0, 0, 1, 32'h8000_0300,  1, 32'h0000_0000, 0, 32'h0, 32'h0));
    vq.push_back(mk(0, 1, 32'h4444_0005, 0, 0, 32'h0,  0, 32'h0, 0, 32'h0, 32'h0));
    vq.push_back(mk(0, 0, 32'h0, 0, 1, 32'h8000_0400,  1, 32'h8000_0300, 0, 32'h0, 32'h0));
    vq.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0,  1, 32'h8000_0400, 0, 32'h0, 32'h0));
    vq.push_back(mk(0, 1, 32'h5555_0006, 0, 1, 32'h8000_0500,  0, 32'h0, 0, 32'h0, 32'h0));
    vq.push_back(mk(1, 0, 32'h0, 0, 0, 32'h0,  1, 32'h8000_0500, 0, 32'h0, 32'h0));
    vq.push_back(mk(0, 1, 32'h6666_0007, 0, 0, 32'h0,  0, 32'h0, 0, 32'h0, 32'h0));
    vq.push_back(mk(0, 0, 32'h0, 1, 0, 32'h0,  0, 32'h0, 1, 32'h6666_0007, 32'h8000_0500));
    vq.push_back(mk(0, 0, 32'h0, 0, 0, 32'h0,  1, 32'h8000_0504, 0, 32'h0, 32'h0));

    rst = 1'b1;
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk); #1;
    chk("reset req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("reset inst_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1;
    chk("post-reset inst", inst, 32'h0);
`ifdef IFU_MISALIGN_CHK_EN
    chk("post-reset fetch_err", {31'd0, fetch_err}, 32'd0);
`endif

    for (int i = 0; i < vq.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive(vq[i].rdy, vq[i].rsp, vq[i].rdata, vq[i].ird, vq[i].redv, vq[i].rpc);
      #1;
      $display("vec %0d: req_valid=%0b addr=%h inst_valid=%0b inst=%h inst_pc=%h",
               i, imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc);
      chk($sformatf("v%0d req_valid", i), {31'd0, imem_req_valid}, {31'd0, vq[i].e_rv});
      if (vq[i].e_rv) chk($sformatf("v%0d req_addr", i), imem_req_addr, vq[i].e_addr);
      chk($sformatf("v%0d inst_valid", i), {31'd0, inst_valid}, {31'd0, vq[i].e_iv});
      if (vq[i].e_iv) begin
        chk($sformatf("v%0d inst", i), inst, vq[i].e_inst);
        chk($sformatf("v%0d inst_pc", i), inst_pc, vq[i].e_ipc);
      end
      if (vq[i].rsp) begin
        chk($sformatf("v%0d resp outstanding", i), {31'd0, outstanding}, 32'd1);
        outstanding = 1'b0;
      end
      if (imem_req_valid && vq[i].rdy) outstanding = 1'b1;
    end

    // Reset while a request is outstanding.
    @(negedge clk);
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    #1;
    $display("seq reset-mid: accept addr=%h", imem_req_addr);
    chk("mid accept addr", imem_req_addr, 32'h8000_0504);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    #1;
    chk("mid reset req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("mid reset inst_valid", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1;
    $display("seq reset-mid: after release req_valid=%0b addr=%h", imem_req_valid, imem_req_addr);
    chk("mid reset release req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("mid reset release addr", imem_req_addr, 32'h8000_0000);
    chk("mid reset inst cleared", inst, 32'h0);

    // Misaligned redirect target.
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 1, 32'h8000_0102);
    #1;
`ifdef IFU_MISALIGN_CHK_EN
    chk("misalign same-cycle req_valid", {31'd0, imem_req_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1, 0, 32'h0, 0, 0, 32'h0);
      #1;
      $display("seq misalign %0d: fetch_err=%0b req_valid=%0b", k, fetch_err, imem_req_valid);
      chk($sformatf("misalign fetch_err %0d", k), {31'd0, fetch_err}, 32'd1);
      chk($sformatf("misalign halted %0d", k), {31'd0, imem_req_valid}, 32'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("misalign cleared by rst", {31'd0, fetch_err}, 32'd0);
    chk("misalign restart req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("misalign restart addr", imem_req_addr, 32'h8000_0000);
`else
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    #1;
    $display("seq misalign: req_valid=%0b addr=%h", imem_req_valid, imem_req_addr);
    chk("misalign masked req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("misalign masked addr", imem_req_addr, 32'h8000_0100);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
